// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial unsigned subtractor. Computes minuend - subtrahend
//                one bit per clock, LSB first, with a single full-subtractor
//                cell and a borrow flop. Start/busy/done handshake.
//                Optional macro SERIAL_SUBTRACTOR_OVERFLOW_EN adds o_overflow
//                (signed two's-complement overflow of the subtraction).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int BITS = 4
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [BITS-1:0] i_minuend,
   input  logic [BITS-1:0] i_subtrahend,
   output logic [BITS-1:0] o_difference,
   output logic            o_borrow,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   output logic            o_overflow,
`endif
   output logic            o_busy,
   output logic            o_done
);

   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [BITS-1:0] minuend_sr;
   logic [BITS-1:0] subtrahend_sr;
   logic [BITS-1:0] result_sr;
   logic            borrow_q;
   logic [CW-1:0]   bit_count;

   logic            bit_a;
   logic            bit_b;
   logic            bit_d;
   logic            bit_bout;
   logic [BITS-1:0] result_next;

   // Full-subtractor cell on the current LSB of the operand shift registers
   assign bit_a       = minuend_sr[0];
   assign bit_b       = subtrahend_sr[0];
   assign bit_d       = bit_a ^ bit_b ^ borrow_q;
   assign bit_bout    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
   // Difference bits enter at the MSB so that after BITS shifts they sit LSB-aligned
   assign result_next = {bit_d, result_sr[BITS-1:1]};

   assign o_busy = (state == RUN);
   assign o_done = (state == DONE);

   // Handshake FSM, serial datapath and registered result outputs
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state         <= IDLE;
         minuend_sr    <= '0;
         subtrahend_sr <= '0;
         result_sr     <= '0;
         borrow_q      <= 1'b0;
         bit_count     <= '0;
         o_difference  <= '0;
         o_borrow      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
         o_overflow    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               // DONE accepts a new request exactly like IDLE for back-to-back issue
               if (i_start) begin
                  minuend_sr    <= i_minuend;
                  subtrahend_sr <= i_subtrahend;
                  result_sr     <= '0;
                  borrow_q      <= 1'b0;
                  bit_count     <= '0;
                  state         <= RUN;
               end else begin
                  state         <= IDLE;
               end
            end
            RUN: begin
               minuend_sr    <= minuend_sr >> 1;
               subtrahend_sr <= subtrahend_sr >> 1;
               result_sr     <= result_next;
               borrow_q      <= bit_bout;
               bit_count     <= bit_count + CW'(1);
               if (bit_count == LAST_BIT) begin
                  // On the last bit the operand LSBs are the original MSBs
                  o_difference <= result_next;
                  o_borrow     <= bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                  o_overflow   <= (bit_a != bit_b) && (bit_d != bit_a);
`endif
                  state        <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (BITS=4) with a
//                scoreboard queue of expected results popped on o_done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   typedef struct packed {
      logic [3:0] diff;
      logic       borrow;
      logic       ovf;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] minu;
   logic [3:0] subt;
   logic [3:0] difference;
   logic       borrow;
   logic       ovf;
   logic       busy;
   logic       done;

   int   checks;
   int   errors;
   exp_t sb[$];

   serial_subtractor #(.BITS(4)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_minuend    (minu),
      .i_subtrahend (subt),
      .o_difference (difference),
      .o_borrow     (borrow),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      .o_overflow   (ovf),
`endif
      .o_busy       (busy),
      .o_done       (done)
   );

`ifndef SERIAL_SUBTRACTOR_OVERFLOW_EN
   assign ovf = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: unsigned difference, borrow, signed overflow
   function automatic exp_t model(input int x, input int y);
      exp_t e;
      logic [3:0] a;
      logic [3:0] b;
      a = 4'(x);
      b = 4'(y);
      e.diff   = 4'((x - y) & 15);
      e.borrow = (x < y);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      e.ovf    = (a[3] != b[3]) && (e.diff[3] != a[3]);
`else
      e.ovf    = 1'b0;
`endif
      return e;
   endfunction

   // Scoreboard: every o_done pops one expected result
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got diff=%0d borrow=%0b with no request outstanding", difference, borrow);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({difference, borrow, ovf} !== {e.diff, e.borrow, e.ovf}) begin
               errors++;
               $display("FAIL result: got diff=%0d borrow=%0b ovf=%0b, expected diff=%0d borrow=%0b ovf=%0b",
                        difference, borrow, ovf, e.diff, e.borrow, e.ovf);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; minu = '0; subt = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({difference, borrow, ovf, busy, done} !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: got diff=%0d borrow=%0b ovf=%0b busy=%0b done=%0b, expected all 0",
                  difference, borrow, ovf, busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_exhaustive();
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            int first_done;
            int done_cnt;
            @(negedge clk);
            start = 1'b1; minu = 4'(x); subt = 4'(y);
            sb.push_back(model(x, y));
            @(posedge clk);
            first_done = 0;
            done_cnt   = 0;
            for (int i = 1; i <= 8; i++) begin
               @(negedge clk);
               if (i == 1) start = 1'b0;
               if (done === 1'b1) begin
                  done_cnt++;
                  if (first_done == 0) first_done = i;
               end
            end
            checks++;
            if (first_done != 5) begin
               errors++;
               $display("FAIL latency %0d-%0d: got done at cycle %0d, expected 5", x, y, first_done);
            end
            checks++;
            if (done_cnt != 1) begin
               errors++;
               $display("FAIL done_width %0d-%0d: got %0d done cycles, expected 1", x, y, done_cnt);
            end
         end
      end
   endtask

   task automatic test_basic();
      int   xs[4] = '{9, 3, 7, 0};
      int   ys[4] = '{3, 9, 7, 1};
      logic [3:0] ed[4] = '{4'd6, 4'd10, 4'd0, 4'd15};
      logic eb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         bit   got;
         e = model(xs[k], ys[k]);
         e.diff = ed[k];
         e.borrow = eb[k];
         @(negedge clk);
         start = 1'b1; minu = 4'(xs[k]); subt = 4'(ys[k]);
         sb.push_back(e);
         @(posedge clk);
         got = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin got = 1'b1; break; end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL basic_timeout %0d-%0d: got no done, expected done", xs[k], ys[k]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int busy_cnt;
      int done_cnt;
      @(negedge clk);
      start = 1'b1; minu = 4'd12; subt = 4'd5;
      sb.push_back(model(12, 5));
      @(posedge clk);
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 2) begin start = 1'b1; minu = 4'd1; subt = 4'd1; end
         else start = 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (busy_cnt != 4) begin
         errors++;
         $display("FAIL busy_cycles: got %0d, expected 4", busy_cnt);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL ignored_start: got %0d results, expected 1", done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      bit got;
      @(negedge clk);
      start = 1'b1; minu = 4'd8; subt = 4'd1;
      sb.push_back(model(8, 1));
      @(posedge clk);
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL b2b_first_timeout: got no done, expected done");
      end
      minu = 4'd2; subt = 4'd4;
      sb.push_back(model(2, 4));
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_no_idle: got busy=%0b, expected 1", busy);
      end
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL b2b_second_timeout: got no done, expected done");
      end
   endtask

   task automatic test_reset_mid_run();
      bit got;
      @(negedge clk);
      start = 1'b1; minu = 4'd15; subt = 4'd1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({difference, borrow, ovf, busy, done} !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_run: got diff=%0d borrow=%0b ovf=%0b busy=%0b done=%0b, expected all 0",
                  difference, borrow, ovf, busy, done);
      end
      repeat (6) @(negedge clk);
      start = 1'b1; minu = 4'd5; subt = 4'd2;
      sb.push_back(model(5, 2));
      @(posedge clk);
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL after_reset_timeout: got no done, expected done");
      end
   endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   task automatic test_overflow();
      int   xs[3] = '{7, 8, 5};
      int   ys[3] = '{8, 1, 3};
      logic [5:0] ex[3] = '{{4'd15, 1'b1, 1'b1}, {4'd7, 1'b0, 1'b1}, {4'd2, 1'b0, 1'b0}};
      for (int k = 0; k < 3; k++) begin
         bit got;
         @(negedge clk);
         start = 1'b1; minu = 4'(xs[k]); subt = 4'(ys[k]);
         sb.push_back(exp_t'(ex[k]));
         @(posedge clk);
         got = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin got = 1'b1; break; end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL ovf_timeout %0d-%0d: got no done, expected done", xs[k], ys[k]);
         end
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_exhaustive();
      test_basic();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      test_overflow();
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
